// File: rtl/i2c_slave_responder.sv
// i2c_slave_responder: oversampled I2C target with 7-bit address match, ACK, receive and transmit.
// Optional macro I2C_GLITCH_FILTER_EN adds a FILT_CYCLES-deep glitch filter after the synchronizers.
module i2c_slave_responder #(
  parameter logic [6:0] ADDR        = 7'h42,
  parameter int         SYNC_STAGES = 2,
  parameter int         FILT_CYCLES = 3
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oe_o,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  input  logic [7:0] tx_data_i,
  output logic       tx_req_o,
  output logic       rw_o,
  output logic       busy_o,
  output logic       start_det_o,
  output logic       stop_det_o
);
  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_RX_BYTE, S_RX_ACK, S_TX_BYTE, S_TX_ACK, S_WAIT_STOP
  } state_t;
  if (SYNC_STAGES < 2 || FILT_CYCLES < 1) begin : g_param_check
    $error("i2c_slave_responder: SYNC_STAGES must be >= 2 and FILT_CYCLES >= 1");
  end
  logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
  logic scl_s, sda_s, scl_p_q, sda_p_q;
  // Synchronizers reset to the idle bus level so reset release never looks like an edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
    end else begin
      scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_i};
      sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_i};
    end
  end
`ifdef I2C_GLITCH_FILTER_EN
  localparam int FW = $clog2(FILT_CYCLES + 1);
  logic [FW-1:0] scl_cnt_q, sda_cnt_q;
  logic scl_f_q, sda_f_q;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      scl_cnt_q <= '0;
      sda_cnt_q <= '0;
      scl_f_q   <= 1'b1;
      sda_f_q   <= 1'b1;
    end else begin
      scl_cnt_q <= (scl_sync_q[SYNC_STAGES-1] == scl_f_q) ? '0 : scl_cnt_q + 1'b1;
      sda_cnt_q <= (sda_sync_q[SYNC_STAGES-1] == sda_f_q) ? '0 : sda_cnt_q + 1'b1;
      if (scl_sync_q[SYNC_STAGES-1] != scl_f_q && scl_cnt_q == FW'(FILT_CYCLES - 1)) begin
        scl_f_q   <= ~scl_f_q;
        scl_cnt_q <= '0;
      end
      if (sda_sync_q[SYNC_STAGES-1] != sda_f_q && sda_cnt_q == FW'(FILT_CYCLES - 1)) begin
        sda_f_q   <= ~sda_f_q;
        sda_cnt_q <= '0;
      end
    end
  end
  assign scl_s = scl_f_q;
  assign sda_s = sda_f_q;
`else
  assign scl_s = scl_sync_q[SYNC_STAGES-1];
  assign sda_s = sda_sync_q[SYNC_STAGES-1];
`endif
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      scl_p_q <= 1'b1;
      sda_p_q <= 1'b1;
    end else begin
      scl_p_q <= scl_s;
      sda_p_q <= sda_s;
    end
  end
  logic start_ev, stop_ev, scl_rise, scl_fall;
  logic [7:0] byte_in;
  assign start_ev = scl_s & scl_p_q & sda_p_q & ~sda_s;
  assign stop_ev  = scl_s & scl_p_q & ~sda_p_q & sda_s;
  assign scl_rise = scl_s & ~scl_p_q;
  assign scl_fall = ~scl_s & scl_p_q;
  state_t state_q;
  logic [2:0] cnt_q;
  logic [7:0] shift_q, rx_data_q;
  logic sda_oe_q, rx_valid_q, tx_req_q, rw_q, busy_q, start_det_q, stop_det_q, ack_q;
  assign byte_in = {shift_q[6:0], sda_s};
  // ack_q marks that the ACK bit is being driven; the next SCL fall ends it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      shift_q     <= '0;
      rx_data_q   <= '0;
      sda_oe_q    <= 1'b0;
      rx_valid_q  <= 1'b0;
      tx_req_q    <= 1'b0;
      rw_q        <= 1'b0;
      busy_q      <= 1'b0;
      start_det_q <= 1'b0;
      stop_det_q  <= 1'b0;
      ack_q       <= 1'b0;
    end else begin
      rx_valid_q  <= 1'b0;
      tx_req_q    <= 1'b0;
      start_det_q <= 1'b0;
      stop_det_q  <= 1'b0;
      if (stop_ev) begin
        state_q    <= S_IDLE;
        sda_oe_q   <= 1'b0;
        stop_det_q <= 1'b1;
        busy_q     <= 1'b0;
        cnt_q      <= '0;
        ack_q      <= 1'b0;
      end else if (start_ev) begin
        state_q     <= S_ADDR;
        sda_oe_q    <= 1'b0;
        start_det_q <= 1'b1;
        busy_q      <= 1'b1;
        cnt_q       <= '0;
        ack_q       <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: ;
          S_ADDR: if (scl_rise) begin
            shift_q <= byte_in;
            cnt_q   <= cnt_q + 1'b1;
            if (cnt_q == 3'd7) begin
              if (byte_in[7:1] == ADDR && byte_in[7:1] != 7'd0) begin
                rw_q    <= byte_in[0];
                state_q <= S_ADDR_ACK;
              end else state_q <= S_WAIT_STOP;
            end
          end
          S_ADDR_ACK, S_RX_ACK: if (scl_fall) begin
            if (!ack_q) begin
              ack_q    <= 1'b1;
              sda_oe_q <= 1'b1;
              tx_req_q <= (state_q == S_ADDR_ACK) && rw_q;
            end else begin
              ack_q <= 1'b0;
              if (state_q == S_ADDR_ACK && rw_q) begin
                shift_q  <= tx_data_i;
                sda_oe_q <= ~tx_data_i[7];
                state_q  <= S_TX_BYTE;
              end else begin
                sda_oe_q <= 1'b0;
                state_q  <= S_RX_BYTE;
              end
            end
          end
          S_RX_BYTE: if (scl_rise) begin
            shift_q <= byte_in;
            cnt_q   <= cnt_q + 1'b1;
            if (cnt_q == 3'd7) begin
              rx_data_q  <= byte_in;
              rx_valid_q <= 1'b1;
              state_q    <= S_RX_ACK;
            end
          end
          S_TX_BYTE: if (scl_fall) begin
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == 3'd7) begin
              sda_oe_q <= 1'b0;
              state_q  <= S_TX_ACK;
            end else begin
              sda_oe_q <= ~shift_q[6];
              shift_q  <= {shift_q[6:0], 1'b0};
            end
          end
          S_TX_ACK: begin
            if (scl_rise && !ack_q) begin
              if (sda_s) state_q <= S_WAIT_STOP;
              else begin
                tx_req_q <= 1'b1;
                ack_q    <= 1'b1;
              end
            end else if (scl_fall && ack_q) begin
              ack_q    <= 1'b0;
              shift_q  <= tx_data_i;
              sda_oe_q <= ~tx_data_i[7];
              state_q  <= S_TX_BYTE;
            end
          end
          S_WAIT_STOP: sda_oe_q <= 1'b0;
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end
  assign sda_oe_o    = sda_oe_q;
  assign rx_data_o   = rx_data_q;
  assign rx_valid_o  = rx_valid_q;
  assign tx_req_o    = tx_req_q;
  assign rw_o        = rw_q;
  assign busy_o      = busy_q;
  assign start_det_o = start_det_q;
  assign stop_det_o  = stop_det_q;
endmodule
